softsign_divider: RTL and testbench

Downstream of the denominator stage in the neuron activation path. Consumes the raw neuron sum X and the denominator 1+|X|, and computes the softsign activation Y = X/(1+|X|). The quotient is produced by a sequential restoring divider, one quotient bit per clock. The result is a signed fixed-point fraction that goes to the next layer's weight multipliers.

---
 rtl/softsign_divider_if.sv | 14 +
 rtl/softsign_divider.sv | 110 +++++++++++
 tb/tb_softsign_divider.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/softsign_divider_if.sv
// Handshake bundle between the denominator stage and the softsign divider.
// The upstream side drives X/denom/start; the divider drives the result side.
interface softsign_divider_if;
  logic [31:0] X;
  logic [31:0] denom;
  logic        start;
  logic [31:0] Y;
  logic        done;
  logic        busy;
  logic        err;

  modport master (output X, denom, start, input  Y, done, busy, err);
  modport slave  (input  X, denom, start, output Y, done, busy, err);
endinterface

// File: rtl/softsign_divider.sv
// Softsign activation Y = X/(1+|X|) via a sequential restoring divider,
// one quotient bit per clock; result is signed Q(31-FRAC_BITS).FRAC_BITS.
module softsign_divider #(
  parameter int FRAC_BITS = 16
) (
  input  logic              CLOCK,
  input  logic              reset,
  softsign_divider_if.slave bus
);

  localparam int CW = $clog2(FRAC_BITS + 1);

  typedef enum logic [1:0] {IDLE, DIV, FIN} state_t;

  // Only the low 32 remainder bits feed the next shift, so bit 32 of the
  // nominal 33-bit remainder is never stored.
  typedef struct packed {
    logic                 sign;
    logic [31:0]          div;
    logic [31:0]          rem;
    logic [FRAC_BITS-1:0] q;
    logic [CW-1:0]        cnt;
  } dp_t;

  state_t      st, st_n;
  dp_t         dp, dp_n;
  logic [31:0] y_q, y_n;
  logic        done_q, done_n;
  logic        busy_q, busy_n;
  logic        err_q, err_n;

  logic [32:0]          t;
  logic [31:0]          diff;
  logic                 ge;
  logic [FRAC_BITS:0]   qs;
  logic [31:0]          mag;
  logic [31:0]          m;

  always_ff @(posedge CLOCK or negedge reset) begin
    if (!reset) begin
      st     <= IDLE;
      dp     <= '0;
      y_q    <= '0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      st     <= st_n;
      dp     <= dp_n;
      y_q    <= y_n;
      done_q <= done_n;
      busy_q <= busy_n;
      err_q  <= err_n;
    end
  end

  always_comb begin
    st_n   = st;
    dp_n   = dp;
    y_n    = y_q;
    done_n = 1'b0;
    busy_n = busy_q;
    err_n  = err_q;

    t    = {dp.rem, 1'b0};
    ge   = (t >= {1'b0, dp.div});
    // Low 32 bits of t-div are exact whenever ge holds for consistent inputs.
    diff = t[31:0] - dp.div;
    qs   = {dp.q, ge};
    mag  = bus.X[31] ? (~bus.X + 32'd1) : bus.X;
    m    = err_q ? {{(32-FRAC_BITS){1'b0}}, {FRAC_BITS{1'b1}}}
                 : {{(32-FRAC_BITS){1'b0}}, dp.q};

    case (st)
      IDLE: begin
        if (bus.start) begin
          dp_n.sign = bus.X[31];
          dp_n.div  = bus.denom;
          dp_n.rem  = mag;
          dp_n.q    = '0;
          dp_n.cnt  = CW'(FRAC_BITS);
          busy_n    = 1'b1;
          err_n     = (bus.denom == 32'd0);
          st_n      = DIV;
        end
      end
      DIV: begin
        dp_n.rem = ge ? diff : t[31:0];
        dp_n.q   = qs[FRAC_BITS-1:0];
        dp_n.cnt = dp.cnt - CW'(1);
        if (dp.cnt == CW'(1))
          st_n = FIN;
      end
      FIN: begin
        // m is zero when X is zero, so negation never yields -0.
        y_n    = dp.sign ? (~m + 32'd1) : m;
        done_n = 1'b1;
        busy_n = 1'b0;
        st_n   = IDLE;
      end
      default: st_n = IDLE;
    endcase
  end

  assign bus.Y    = y_q;
  assign bus.done = done_q;
  assign bus.busy = busy_q;
  assign bus.err  = err_q;

endmodule

// File: tb/tb_softsign_divider.sv
// Scoreboard bench for softsign_divider: stimulus pushes expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_softsign_divider;
  localparam int F = 16;

  logic clk;
  logic rst;
  softsign_divider_if bus();

  softsign_divider #(.FRAC_BITS(F)) dut (
    .CLOCK (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] y;
    logic        e;
    int          cyc;
    string       nm;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference: plain long division of |X|*2^F by denom, then re-apply the sign.
  function automatic logic [31:0] ref_y(input logic [31:0] x, input logic [31:0] d);
    longint unsigned mg, mm;
    logic [31:0] ax;
    ax = x[31] ? (32'd0 - x) : x;
    mg = {32'd0, ax};
    if (d == 32'd0) mm = (64'd1 << F) - 64'd1;
    else            mm = ((mg << F) / {32'd0, d}) & ((64'd1 << F) - 64'd1);
    return x[31] ? 32'(64'd0 - mm) : 32'(mm);
  endfunction

  always @(negedge clk) begin
    if (rst && bus.done) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done with Y=%h want no done", bus.Y);
      end else begin
        mon_e = sb.pop_front();
        chk({mon_e.nm, "_Y"}, bus.Y, mon_e.y);
        chk({mon_e.nm, "_done_cycle"}, cyc, mon_e.cyc);
        chk({mon_e.nm, "_err"}, {31'd0, bus.err}, {31'd0, mon_e.e});
        chk({mon_e.nm, "_busy_low"}, {31'd0, bus.busy}, 32'd0);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: got busy=1 want busy=0 within 200 cycles");
    end
  endtask

  task automatic issue(input logic [31:0] x, input logic [31:0] d, input string nm,
                       input bit hold = 1'b0);
    wait_idle();
    @(negedge clk);
    bus.X     = x;
    bus.denom = d;
    bus.start = 1'b1;
    sb.push_back('{ref_y(x, d), (d == 32'd0), cyc + F + 2, nm});
    @(posedge clk);
    #1;
    chk({nm, "_busy_cap"}, {31'd0, bus.busy}, 32'd1);
    chk({nm, "_err_cap"}, {31'd0, bus.err}, {31'd0, (d == 32'd0)});
    if (!hold) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] x, d, ax, ylast;
    int n;
    rst       = 1'b0;
    bus.X     = '0;
    bus.denom = '0;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_Y", bus.Y, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_err", {31'd0, bus.err}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    issue(32'd1, 32'd2, "pos");
    issue(32'hFFFF_FFFD, 32'd4, "neg3");
    issue(32'd0, 32'd1, "zero");
    issue(32'h8000_0000, 32'h8000_0001, "minint");
    issue(32'h7FFF_FFFF, 32'h8000_0000, "maxint");
    issue(32'd5, 32'd0, "divzero");
    issue(32'hFFFF_FFFB, 32'd0, "divzero_neg");
    issue(32'd1, 32'd2, "err_clear");

    // Starts during DIV with different operands must not disturb the result.
    issue(32'd3, 32'd4, "ign");
    repeat (8) begin
      @(negedge clk);
      bus.X     = 32'd7;
      bus.denom = 32'd9;
      bus.start = 1'b1;
    end
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle();
    repeat (4) @(negedge clk);
    chk("ign_hold", bus.Y, ref_y(32'd3, 32'd4));

    // Start held through done: second capture on the edge after done.
    issue(32'd20, 32'd21, "b2b_a", 1'b1);
    n = 0;
    while (!bus.done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.done) begin
      total++;
      bad++;
      $display("FAIL b2b_wait: got no done want done within 100 cycles");
    end
    bus.X     = 32'hFFFF_FF00;
    bus.denom = 32'd257;
    sb.push_back('{ref_y(32'hFFFF_FF00, 32'd257), 1'b0, cyc + F + 2, "b2b_b"});
    @(posedge clk);
    #1;
    chk("b2b_b_busy_cap", {31'd0, bus.busy}, 32'd1);
    @(negedge clk);
    bus.start = 1'b0;

    // Asynchronous reset mid-divide: outputs clear at once, no done later.
    issue(32'd9, 32'd0, "rst_mid");
    ylast = bus.Y;
    repeat (7) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("rstmid_Y", bus.Y, 32'd0);
    chk("rstmid_done", {31'd0, bus.done}, 32'd0);
    chk("rstmid_busy", {31'd0, bus.busy}, 32'd0);
    chk("rstmid_err", {31'd0, bus.err}, 32'd0);
    chk("rstmid_prev_Y_nonzero", {31'd0, (ylast != 32'd0)}, 32'd1);
    void'(sb.pop_back());
    @(negedge clk);
    rst = 1'b1;
    repeat (25) @(negedge clk);

    issue(32'hFFFF_FFF6, 32'd11, "chain_m10");

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        x = $urandom;
      end else begin
        x = $urandom_range(0, 200);
        if ($urandom_range(0, 1) == 1) x = 32'd0 - x;
      end
      ax = x[31] ? (32'd0 - x) : x;
      if ($urandom_range(0, 3) != 0) d = ax + 32'd1;
      else                           d = ax + 32'd1 + ($urandom & 32'h3FFF_FFFF);
      issue(x, d, "rand");
    end

    wait_idle();
    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending results want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end
endmodule
